fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage of the Redux-V datapath. It sits directly around program_counter: it consumes cur_pc and drives n_pc back into it. It issues a req/ack read to instruction memory and holds the fetched 8-bit instruction for decode under a valid/ready handshake. It also applies branch redirects from execute, including squashing any in-flight fetch.

Parameters:
ADDR_W, 8, PC / instruction-memory address width
DATA_W, 8, instruction width
RESET_VECTOR, 8'd0, first PC value after reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
cur_pc  in  ADDR_W  current PC from program_counter
n_pc  out  ADDR_W  next PC; program_counter loads it every clk edge
imem_req  out  1  instruction-memory read request
imem_addr  out  ADDR_W  read address, registered, stable while imem_req=1
imem_ack  in  1  memory has the read data this cycle
imem_data  in  DATA_W  read data, valid when imem_ack=1
instr  out  DATA_W  fetched instruction to decode
instr_valid  out  1  instr is valid
instr_ready  in  1  decode accepts instr this cycle
br_taken  in  1  redirect from execute, single-cycle pulse
br_target  in  ADDR_W  redirect target, valid with br_taken

Behaviour:
- program_counter has no reset or enable. Stalling is therefore "n_pc = cur_pc" (hold). n_pc is combinational from state and inputs; every other output is registered.
- Registers: state, addr_q (drives imem_addr), ir_q (drives instr).
- Reset (rst_n=0 at a clk edge):
  - state<=RST, addr_q<=RESET_VECTOR, ir_q<=0.
  - While rst_n=0, n_pc=RESET_VECTOR, so the PC is initialised.
  - Mid-operation reset drops any outstanding request with no drain. The memory model must tolerate this.
- States: RST, FETCH, DRAIN, HOLD. Whenever a transition enters FETCH, addr_q<=n_pc, so addr_q always equals cur_pc in FETCH.
- RST:
  - imem_req=0, instr_valid=0, n_pc=RESET_VECTOR.
  - Next cycle goes to FETCH.
- FETCH:
  - imem_req=1, instr_valid=0.
  - br_taken: n_pc=br_target. If imem_ack in the same cycle, discard data and go to FETCH (addr_q<=br_target); otherwise go to DRAIN.
  - else imem_ack: ir_q<=imem_data, go to HOLD, n_pc=cur_pc.
  - else: stay, n_pc=cur_pc.
- DRAIN: completes the squashed request, since req must never drop before ack.
  - imem_req=1 with the old addr_q; data is discarded.
  - br_taken: n_pc=br_target. The latest redirect wins.
  - imem_ack: go to FETCH (addr_q<=n_pc).
  - Otherwise n_pc=cur_pc.
- HOLD:
  - instr_valid=1, imem_req=0.
  - br_taken (priority over instr_ready): n_pc=br_target, instr flushed (not consumed even if instr_ready=1), go to FETCH.
  - else instr_ready: n_pc=cur_pc+1, go to FETCH.
  - else: stay, n_pc=cur_pc; instr and instr_valid stable.
- Arithmetic: cur_pc+1 is modulo 2^ADDR_W, so 8'hFF wraps to 8'h00 with no flag.
- Throughput: with zero-wait memory (ack in the req cycle) and ready=1, one instruction per 2 cycles. Each memory wait cycle adds 1.
- imem_ack outside FETCH/DRAIN is ignored. br_taken in RST is ignored.

Decomposition:
- Shared package redux_pkg:
  - state enum fetch_state_t {RST, FETCH, DRAIN, HOLD}
  - ADDR_W and DATA_W defaults
  - RESET_VECTOR
- No sub-module: the incrementer and next-PC mux stay inline in a single combinational block. The state register block is separate.

Test Plan:
- Reset then zero-wait memory (ack same cycle), ready=1, imem[k]=k+8'h40 -> imem_addr 0,1,2,3 on alternate cycles; instr 8'h40,8'h41,8'h42; instr_valid pulses every 2nd cycle.
- 3-cycle ack latency at addr 5 -> imem_req=1 and imem_addr=5 held 3 cycles; n_pc=5 throughout; instr valid on the cycle after ack.
- instr_ready=0 for 4 cycles in HOLD with cur_pc=9 -> instr stable, n_pc=9; on ready, n_pc=10 and next imem_addr=10.
- br_taken with target 8'h20 during FETCH, with ack 2 cycles later -> n_pc=8'h20 that cycle; DRAIN keeps the old addr; data discarded (no instr_valid); next imem_addr=8'h20.
- br_taken with target 8'h30 while HOLD and instr_ready=1 -> instr not consumed, n_pc=8'h30. Then cur_pc=8'hFF accepted -> n_pc=8'h00.
- rst_n=0 mid-FETCH with cur_pc=7 -> next cycle imem_req=0, instr_valid=0, n_pc=RESET_VECTOR; after release the fetch restarts at 0.

Source files
------------

// File: rtl/redux_pkg.sv
// Shared Redux-V definitions: datapath widths, reset vector and fetch FSM states.
package redux_pkg;

  localparam int unsigned REDUX_ADDR_W = 8;
  localparam int unsigned REDUX_DATA_W = 8;
  localparam logic [REDUX_ADDR_W-1:0] REDUX_RESET_VECTOR = REDUX_ADDR_W'(0);

  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack read port plus the
// valid/ready instruction handshake towards decode.
//   imem_req/imem_addr   fetch -> memory, registered request and address
//   imem_ack/imem_data   memory -> fetch, data valid while imem_ack=1
//   instr/instr_valid    fetch -> decode, registered instruction
//   instr_ready          decode -> fetch, accepts instr this cycle
interface fetch_unit_if
  import redux_pkg::*;
#(
  parameter int unsigned ADDR_W = REDUX_ADDR_W,
  parameter int unsigned DATA_W = REDUX_DATA_W
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_data;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ack, imem_data, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_data, instr_ready
  );

endinterface

// File: rtl/fetch_unit.sv
// Redux-V instruction fetch stage. Drives the next PC into an external
// program counter (no reset/enable of its own, so a stall is n_pc = cur_pc),
// reads instruction memory through a req/ack port and presents the fetched
// instruction to decode with valid/ready. Branch redirects squash any
// in-flight read by draining it before refetching.
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   cur_pc     current PC from program_counter
//   n_pc       next PC, combinational, loaded by program_counter every edge
//   br_taken   single-cycle redirect pulse from execute
//   br_target  redirect target, valid with br_taken
//   bus        memory port and decode handshake (master side)
module fetch_unit
  import redux_pkg::*;
#(
  parameter int unsigned       ADDR_W       = REDUX_ADDR_W,
  parameter int unsigned       DATA_W       = REDUX_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(REDUX_RESET_VECTOR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cur_pc,
  output logic [ADDR_W-1:0] n_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  fetch_unit_if.master      bus
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              req_q, valid_q;

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr       = ir_q;
  assign bus.instr_valid = valid_q;

  // State register; req/valid are decoded from the next state so they are flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RST;
      addr_q  <= RESET_VECTOR;
      ir_q    <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      req_q   <= (state_d == FETCH) || (state_d == DRAIN);
      valid_q <= (state_d == HOLD);
    end
  end

  // Next-state, next-PC mux and incrementer. Every entry into FETCH loads
  // addr_q with n_pc so the request address always tracks cur_pc in FETCH.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    n_pc    = cur_pc;

    case (state_q)
      RST: begin
        n_pc    = RESET_VECTOR;
        state_d = FETCH;
        addr_d  = RESET_VECTOR;
      end

      FETCH: begin
        if (br_taken) begin
          n_pc = br_target;
          // A read completing with the redirect is simply dropped.
          if (bus.imem_ack) begin
            addr_d = br_target;
          end else begin
            state_d = DRAIN;
          end
        end else if (bus.imem_ack) begin
          ir_d    = bus.imem_data;
          state_d = HOLD;
        end
      end

      // Squashed read still outstanding: req must stay up until ack.
      DRAIN: begin
        if (br_taken) begin
          n_pc = br_target;
        end
        if (bus.imem_ack) begin
          state_d = FETCH;
          addr_d  = n_pc;
        end
      end

      // Redirect flushes the held instruction even if decode is ready.
      HOLD: begin
        if (br_taken) begin
          n_pc    = br_target;
          state_d = FETCH;
          addr_d  = br_target;
        end else if (bus.instr_ready) begin
          n_pc    = cur_pc + ADDR_W'(1);
          state_d = FETCH;
          addr_d  = cur_pc + ADDR_W'(1);
        end
      end

      default: begin
        state_d = RST;
      end
    endcase

    // Holding reset initialises the external PC.
    if (!rst_n) begin
      n_pc = RESET_VECTOR;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_fetch_unit;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam logic [7:0]  RV = 8'h00;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cur_pc, n_pc, br_target;
  logic          br_taken;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_VECTOR(RV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cur_pc    (cur_pc),
    .n_pc      (n_pc),
    .br_taken  (br_taken),
    .br_target (br_target),
    .bus       (bus.master)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256];

  // Driver settings
  bit         rand_mode = 1'b0;
  bit         skip_cmp  = 1'b0;
  logic       drv_rst_n = 1'b0;
  logic       drv_ready = 1'b1;
  logic       drv_br    = 1'b0;
  logic [7:0] drv_tgt   = 8'h00;
  int         fixed_lat = 0;

  // Memory model
  bit m_busy = 1'b0;
  int m_cnt  = 0;
  int m_lat  = 0;

  // Behavioural model of the fetch stage
  bit         md_start    = 1'b0;  // first cycle after reset
  bit         md_fetching = 1'b0;  // a read is outstanding
  bit         md_squash   = 1'b0;  // outstanding read will be discarded
  bit         md_have     = 1'b0;  // an instruction is offered to decode
  logic [7:0] md_addr     = 8'h00;
  logic [7:0] md_held     = 8'h00;
  logic [7:0] pc_next     = 8'h00;

  // Per-cycle observations for the directed section
  logic [7:0] obs_addr  [64];
  logic [7:0] obs_instr [64];
  logic [7:0] obs_npc   [64];
  logic       obs_req   [64];
  logic       obs_valid [64];
  int         tn = 0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare, then advance the models.
  task automatic tick();
    logic [7:0] exp_npc;
    logic       ack;
    @(negedge clk);
    if (rand_mode) begin
      drv_rst_n = ($urandom_range(0, 199) != 0);
      drv_ready = ($urandom_range(0, 2) != 0);
      drv_br    = ($urandom_range(0, 5) == 0);
      drv_tgt   = 8'($urandom);
    end
    rst_n           = drv_rst_n;
    bus.instr_ready = drv_ready;
    br_taken        = drv_br;
    br_target       = drv_tgt;
    cur_pc          = pc_next;

    if (bus.imem_req === 1'b1) begin
      if (!m_busy) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        m_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
      bus.imem_ack = (m_cnt == m_lat);
    end else begin
      // Stray acks with no request must be ignored.
      bus.imem_ack = rand_mode && ($urandom_range(0, 7) == 0);
    end
    bus.imem_data = (bus.imem_req === 1'b1 && bus.imem_ack) ? mem[bus.imem_addr] : 8'($urandom);
    #1;

    ack = bus.imem_ack;
    if (!rst_n || md_start)              exp_npc = RV;
    else if (br_taken)                   exp_npc = br_target;
    else if (md_have && bus.instr_ready) exp_npc = 8'(cur_pc + 8'd1);
    else                                 exp_npc = cur_pc;

    if (!skip_cmp) begin
      chk8("n_pc", n_pc, exp_npc);
      chk1("imem_req", bus.imem_req, md_fetching);
      chk1("instr_valid", bus.instr_valid, md_have);
      if (md_fetching) chk8("imem_addr", bus.imem_addr, md_addr);
      if (md_have)     chk8("instr", bus.instr, md_held);
    end

    if (tn < 64) begin
      obs_addr[tn]  = bus.imem_addr;
      obs_instr[tn] = bus.instr;
      obs_npc[tn]   = n_pc;
      obs_req[tn]   = bus.imem_req;
      obs_valid[tn] = bus.instr_valid;
    end
    tn++;

    if (!rst_n) m_busy = 1'b0;
    else if (bus.imem_req === 1'b1 && ack) m_busy = 1'b0;
    else if (m_busy) m_cnt++;

    if (!rst_n) begin
      md_start = 1'b1; md_fetching = 1'b0; md_squash = 1'b0; md_have = 1'b0;
    end else if (md_start) begin
      md_start = 1'b0; md_fetching = 1'b1; md_addr = exp_npc;
    end else if (md_have) begin
      if (br_taken || bus.instr_ready) begin
        md_have = 1'b0; md_fetching = 1'b1; md_addr = exp_npc;
      end
    end else if (md_fetching) begin
      if (ack) begin
        if (md_squash || br_taken) begin
          md_squash = 1'b0; md_addr = exp_npc;
        end else begin
          md_fetching = 1'b0; md_have = 1'b1; md_held = bus.imem_data;
        end
      end else if (br_taken) begin
        md_squash = 1'b1;
      end
    end
    pc_next = exp_npc;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 8'(k + 8'h40);
    rst_n = 1'b0; cur_pc = 8'h00; br_taken = 1'b0; br_target = 8'h00;
    bus.imem_ack = 1'b0; bus.imem_data = 8'h00; bus.instr_ready = 1'b0;

    // Reset
    drv_rst_n = 1'b0;
    skip_cmp = 1'b1; run(1); skip_cmp = 1'b0; run(1);
    chk1("rst_req", bus.imem_req, 1'b0);
    chk1("rst_valid", bus.instr_valid, 1'b0);
    chk8("rst_instr", bus.instr, 8'h00);
    chk8("rst_npc", n_pc, RV);

    // Directed scenarios, cycle t0 = first cycle after release
    drv_rst_n = 1'b1; drv_ready = 1'b1; fixed_lat = 0; drv_br = 1'b0; tn = 0;
    run(11);                                                    // t0..t10
    fixed_lat = 2; run(1); fixed_lat = 0; run(10);              // t11, t12..t21
    drv_ready = 1'b0; run(4); drv_ready = 1'b1; run(1);         // t22..t25, t26
    fixed_lat = 2; drv_br = 1'b1; drv_tgt = 8'h20; run(1);      // t27
    drv_br = 1'b0; fixed_lat = 0; run(3);                       // t28..t30
    drv_br = 1'b1; drv_tgt = 8'h30; run(1); drv_br = 1'b0; run(1);   // t31, t32
    drv_br = 1'b1; drv_tgt = 8'hFF; run(1); drv_br = 1'b0; run(3);   // t33, t34..t36
    drv_br = 1'b1; drv_tgt = 8'h07; run(1); drv_br = 1'b0;           // t37
    fixed_lat = 3; run(1); fixed_lat = 0;                            // t38
    drv_rst_n = 1'b0; run(1); drv_rst_n = 1'b1; run(2);              // t39, t40..t41

    // Zero-wait streaming
    chk1("t0_req", obs_req[0], 1'b0);
    chk8("t0_npc", obs_npc[0], 8'h00);
    for (int i = 0; i < 4; i++) begin
      chk1("zw_req", obs_req[2*i+1], 1'b1);
      chk8("zw_addr", obs_addr[2*i+1], 8'(i));
      chk1("zw_valid_lo", obs_valid[2*i+1], 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      chk1("zw_valid_hi", obs_valid[2*i+2], 1'b1);
      chk8("zw_instr", obs_instr[2*i+2], 8'(8'h40 + i));
    end
    // 3-cycle latency at address 5
    for (int i = 11; i <= 13; i++) begin
      chk1("lat_req", obs_req[i], 1'b1);
      chk8("lat_addr", obs_addr[i], 8'h05);
      chk8("lat_npc", obs_npc[i], 8'h05);
      chk1("lat_valid", obs_valid[i], 1'b0);
    end
    chk1("lat_valid_after", obs_valid[14], 1'b1);
    chk8("lat_instr", obs_instr[14], 8'h45);
    // Decode back-pressure at PC 9
    for (int i = 22; i <= 25; i++) begin
      chk1("bp_valid", obs_valid[i], 1'b1);
      chk8("bp_instr", obs_instr[i], 8'h49);
      chk8("bp_npc", obs_npc[i], 8'h09);
    end
    chk8("bp_release_npc", obs_npc[26], 8'h0A);
    chk8("bp_next_addr", obs_addr[27], 8'h0A);
    // Redirect during FETCH with drain
    chk8("brf_npc", obs_npc[27], 8'h20);
    chk8("drain_addr0", obs_addr[28], 8'h0A);
    chk8("drain_addr1", obs_addr[29], 8'h0A);
    chk1("drain_req", obs_req[29], 1'b1);
    chk1("drain_valid0", obs_valid[28], 1'b0);
    chk1("drain_valid1", obs_valid[29], 1'b0);
    chk1("drain_valid2", obs_valid[30], 1'b0);
    chk8("brf_next_addr", obs_addr[30], 8'h20);
    chk8("brf_instr", obs_instr[31], 8'h60);
    // Redirect during HOLD and PC wrap
    chk8("brh_npc", obs_npc[31], 8'h30);
    chk1("brh_flushed", obs_valid[32], 1'b0);
    chk8("brh_addr", obs_addr[32], 8'h30);
    chk8("brh_instr", obs_instr[33], 8'h70);
    chk8("wrap_br_npc", obs_npc[33], 8'hFF);
    chk8("wrap_instr", obs_instr[35], 8'h3F);
    chk8("wrap_npc", obs_npc[35], 8'h00);
    chk8("wrap_addr", obs_addr[36], 8'h00);
    // Reset in the middle of a fetch
    chk8("mr_fetch_addr", obs_addr[38], 8'h07);
    chk1("mr_fetch_req", obs_req[38], 1'b1);
    chk8("mr_npc_in_rst", obs_npc[39], RV);
    chk1("mr_req", obs_req[40], 1'b0);
    chk1("mr_valid", obs_valid[40], 1'b0);
    chk8("mr_npc", obs_npc[40], RV);
    chk1("mr_restart_req", obs_req[41], 1'b1);
    chk8("mr_restart_addr", obs_addr[41], 8'h00);

    // Randomized traffic
    fixed_lat = -1;
    rand_mode = 1'b1;
    run(4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
